// File: rtl/idt_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// idt_cfg_loader_pkg
// Shared definitions for the IDT pixel-clock synthesizer loader:
//   - bit offsets/widths of the fields inside the 24-bit IDT program word
//     (R[6:0], V[15:7], S[18:16], F[20:19], TTL[21], C[23:22])
//   - idt_pack(): builds a program word from its fields
//   - the loader FSM state encoding
//   - known program words for the supported video modes
//   - clog2_min1(): counter width helper that never returns zero
// No ports; imported by idt_cfg_shift and idt_cfg_loader.
// -----------------------------------------------------------------------------
package idt_cfg_loader_pkg;

  localparam int IDT_W       = 24;

  localparam int IDT_R_LSB   = 0;
  localparam int IDT_R_W     = 7;
  localparam int IDT_V_LSB   = 7;
  localparam int IDT_V_W     = 9;
  localparam int IDT_S_LSB   = 16;
  localparam int IDT_S_W     = 3;
  localparam int IDT_F_LSB   = 19;
  localparam int IDT_F_W     = 2;
  localparam int IDT_TTL_BIT = 21;
  localparam int IDT_C_LSB   = 22;
  localparam int IDT_C_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_STROBE = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  // Program words for the supported video modes.
  typedef enum logic [IDT_W-1:0] {
    MODE_VGA800X600 = 24'h310630
  } idt_mode_e;

  // Assemble an IDT program word from its individual fields.
  function automatic logic [IDT_W-1:0] idt_pack(
    input logic [IDT_C_W-1:0] c,
    input logic               ttl,
    input logic [IDT_F_W-1:0] f,
    input logic [IDT_S_W-1:0] s,
    input logic [IDT_V_W-1:0] v,
    input logic [IDT_R_W-1:0] r
  );
    logic [IDT_W-1:0] w;
    w = '0;
    w[IDT_R_LSB +: IDT_R_W] = r;
    w[IDT_V_LSB +: IDT_V_W] = v;
    w[IDT_S_LSB +: IDT_S_W] = s;
    w[IDT_F_LSB +: IDT_F_W] = f;
    w[IDT_TTL_BIT]          = ttl;
    w[IDT_C_LSB +: IDT_C_W] = c;
    return w;
  endfunction

  // Width of a counter that must hold 0..n-1; at least one bit so that
  // parameter value 1 still yields a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idt_cfg_shift.sv
// -----------------------------------------------------------------------------
// idt_cfg_shift
// Serialiser for one IDT program word, MSB first. Each bit lasts
// 2*SCLK_DIV cycles: SCLK_DIV cycles with sclk low (data set up), then
// SCLK_DIV cycles with sclk high (data held).
// Ports:
//   osc_clk, osc_reset_  clock, async active-low reset
//   i_start              load i_word and begin shifting (taken when o_ready)
//   i_word               word to shift, bit CFG_W-1 first
//   o_ready              no word in flight
//   o_last               final cycle of the final bit (for the controlling FSM)
//   o_sclk, o_data       registered serial clock and data
// -----------------------------------------------------------------------------
module idt_cfg_shift
  import idt_cfg_loader_pkg::*;
#(
  parameter int CFG_W    = 24,
  parameter int SCLK_DIV = 1
) (
  input  logic             osc_clk,
  input  logic             osc_reset_,
  input  logic             i_start,
  input  logic [CFG_W-1:0] i_word,
  output logic             o_ready,
  output logic             o_last,
  output logic             o_sclk,
  output logic             o_data
);

  localparam int BIT_W = clog2_min1(CFG_W);
  localparam int PH_W  = clog2_min1(SCLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);

  // r_sr holds the bits still to be sent, left-aligned; the bit on o_data
  // has already been shifted out of it.
  logic [CFG_W-1:0] r_sr;
  logic [BIT_W-1:0] r_bit;
  logic [PH_W-1:0]  r_phase;
  logic             r_high;
  logic             r_active;
  logic             r_sclk;
  logic             r_data;
  logic             w_phase_end;

  assign w_phase_end = (r_phase == PH_LAST);
  assign o_last      = r_active & r_high & w_phase_end & (r_bit == '0);
  assign o_ready     = ~r_active;
  assign o_sclk      = r_sclk;
  assign o_data      = r_data;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge osc_clk or negedge osc_reset_) begin
    if (!osc_reset_) begin
      r_sr     <= '0;
      r_bit    <= '0;
      r_phase  <= '0;
      r_high   <= 1'b0;
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_data   <= 1'b0;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_data   <= i_word[CFG_W-1];
      r_sr     <= {i_word[CFG_W-2:0], 1'b0};
      r_bit    <= BIT_LAST;
      r_phase  <= '0;
      r_high   <= 1'b0;
      r_sclk   <= 1'b0;
    end else if (r_active) begin
      if (!w_phase_end) begin
        r_phase <= r_phase + 1'b1;
      end else begin
        r_phase <= '0;
        if (!r_high) begin
          r_high <= 1'b1;
          r_sclk <= 1'b1;
        end else begin
          r_high <= 1'b0;
          r_sclk <= 1'b0;
          if (r_bit == '0) begin
            r_active <= 1'b0;
            r_data   <= 1'b0;
          end else begin
            r_bit  <= r_bit - 1'b1;
            r_data <= r_sr[CFG_W-1];
            r_sr   <= {r_sr[CFG_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/idt_cfg_loader.sv
// -----------------------------------------------------------------------------
// idt_cfg_loader
// Runtime-reprogrammable loader for the IDT synthesizer generating idt_clk1.
// Shifts the selected profile word MSB first, pulses strobe, waits for the
// synthesizer to settle and then raises clk_ok (used to hold off the video
// reset). Optionally self-loads AUTO_PROFILE after reset. Requests arriving
// while busy are kept one deep, the most recent select winning.
// Ports:
//   osc_clk, osc_reset_     clock, async active-low reset
//   i_cfg_profiles          profile p at [p*CFG_W +: CFG_W], quasi-static
//   i_load_req, i_load_sel  reload request (pulse or level) and profile index
//   o_busy                  shift/strobe/settle in progress
//   o_done                  one-cycle pulse as o_clk_ok rises
//   o_clk_ok                synthesizer programmed and settled
//   o_cfg_err               sticky: a request selected a nonexistent profile
//   o_idt_sclk/data/strobe  serial interface to the IDT part
// -----------------------------------------------------------------------------
module idt_cfg_loader
  import idt_cfg_loader_pkg::*;
#(
  parameter int CFG_W         = 24,
  parameter int NUM_PROFILES  = 8,
  parameter int SCLK_DIV      = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 100000,
  parameter int AUTO_LOAD     = 1,
  parameter int AUTO_PROFILE  = 0,
  localparam int SEL_W        = clog2_min1(NUM_PROFILES)
) (
  input  logic                          osc_clk,
  input  logic                          osc_reset_,
  input  logic [NUM_PROFILES*CFG_W-1:0] i_cfg_profiles,
  input  logic                          i_load_req,
  input  logic [SEL_W-1:0]              i_load_sel,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_clk_ok,
  output logic                          o_cfg_err,
  output logic                          o_idt_sclk,
  output logic                          o_idt_data,
  output logic                          o_idt_strobe
);

  localparam int STB_W = clog2_min1(STROBE_CYCLES);
  localparam int SET_W = clog2_min1(SETTLE_CYCLES);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] AUTO_SEL = SEL_W'(AUTO_PROFILE);

  state_e           r_state;
  logic             r_auto;      // auto-load still owed since reset
  logic             r_pend;
  logic [SEL_W-1:0] r_pend_sel;
  logic [STB_W-1:0] r_stb_cnt;
  logic [SET_W-1:0] r_set_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_clk_ok;
  logic             r_cfg_err;
  logic             r_strobe;

  logic             w_sel_ok;
  logic             w_req_ok;
  logic             w_req_bad;
  logic             w_start;
  logic             w_shift_ready;
  logic             w_shift_last;
  logic [SEL_W-1:0] w_start_sel;
  logic [CFG_W-1:0] w_start_word;

  assign w_sel_ok  = (32'(i_load_sel) < NUM_PROFILES);
  assign w_req_ok  = i_load_req & w_sel_ok;
  assign w_req_bad = i_load_req & ~w_sel_ok;

  // Source priority when starting from IDLE: the owed auto-load, then a
  // fresh request (newer than anything pending), then the pending one.
  assign w_start     = (r_state == ST_IDLE) & w_shift_ready & (r_auto | w_req_ok | r_pend);
  assign w_start_sel = r_auto   ? AUTO_SEL   :
                       w_req_ok ? i_load_sel : r_pend_sel;
  assign w_start_word = i_cfg_profiles[w_start_sel * CFG_W +: CFG_W];

  idt_cfg_shift #(
    .CFG_W    (CFG_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_shift (
    .osc_clk    (osc_clk),
    .osc_reset_ (osc_reset_),
    .i_start    (w_start),
    .i_word     (w_start_word),
    .o_ready    (w_shift_ready),
    .o_last     (w_shift_last),
    .o_sclk     (o_idt_sclk),
    .o_data     (o_idt_data)
  );

  always_ff @(posedge osc_clk or negedge osc_reset_) begin
    if (!osc_reset_) begin
      r_state    <= ST_IDLE;
      r_auto     <= (AUTO_LOAD != 0);
      r_pend     <= 1'b0;
      r_pend_sel <= '0;
      r_stb_cnt  <= '0;
      r_set_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clk_ok   <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_req_bad) begin
        r_cfg_err <= 1'b1;
      end

      // A valid request that cannot start right now is parked; a later one
      // overwrites the select.
      if (w_req_ok && (r_state != ST_IDLE || r_auto)) begin
        r_pend     <= 1'b1;
        r_pend_sel <= i_load_sel;
      end else if (w_start) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_SHIFT;
            r_busy   <= 1'b1;
            r_clk_ok <= 1'b0;
            r_auto   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_shift_last) begin
            r_state   <= ST_STROBE;
            r_strobe  <= 1'b1;
            r_stb_cnt <= '0;
          end
        end
        ST_STROBE: begin
          if (r_stb_cnt == STB_LAST) begin
            r_state   <= ST_SETTLE;
            r_strobe  <= 1'b0;
            r_set_cnt <= '0;
          end else begin
            r_stb_cnt <= r_stb_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_clk_ok <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_clk_ok     = r_clk_ok;
  assign o_cfg_err    = r_cfg_err;
  assign o_idt_strobe = r_strobe;

endmodule
